// File: rtl/riscv_id_ex.sv
`default_nettype none
// ============================================================================
// Module      : riscv_id_ex
// Description : Decode-to-execute boundary of the 5-stage RISC-V core.
//               Main control decode, load-use hazard detection and the
//               ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_id_ex #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [XLEN-1:0] PC_ID,
  input  logic [XLEN-1:0] REG_DATA1_ID,
  input  logic [XLEN-1:0] REG_DATA2_ID,
  input  logic [XLEN-1:0] IMM_ID,
  input  logic [2:0]      FUNCT3_ID,
  input  logic [6:0]      FUNCT7_ID,
  input  logic [6:0]      OPCODE_ID,
  input  logic [4:0]      RD_ID,
  input  logic [4:0]      RS1_ID,
  input  logic [4:0]      RS2_ID,
  output logic            PC_write,
  output logic            IF_ID_write,
  output logic [XLEN-1:0] PC_EX,
  output logic [XLEN-1:0] REG_DATA1_EX,
  output logic [XLEN-1:0] REG_DATA2_EX,
  output logic [XLEN-1:0] IMM_EX,
  output logic [2:0]      FUNCT3_EX,
  output logic [6:0]      FUNCT7_EX,
  output logic [4:0]      RD_EX,
  output logic [4:0]      RS1_EX,
  output logic [4:0]      RS2_EX,
  output logic            RegWrite_EX,
  output logic            MemtoReg_EX,
  output logic            MemRead_EX,
  output logic            MemWrite_EX,
  output logic            ALUSrc_EX,
  output logic            Branch_EX,
  output logic [1:0]      ALUOp_EX
);

  localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] C_OP_IALU   = 7'b0010011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;

  logic       w_reg_write;
  logic       w_mem_to_reg;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_alu_src;
  logic       w_branch;
  logic [1:0] w_alu_op;
  logic       w_uses_rs1;
  logic       w_uses_rs2;
  logic       w_load_use;
  logic       w_stall;

  // Main control decode from the opcode; unknown opcodes decode as a NOP.
  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_branch     = 1'b0;
    w_alu_op     = 2'b00;
    w_uses_rs1   = 1'b0;
    w_uses_rs2   = 1'b0;
    case (OPCODE_ID)
      C_OP_RTYPE: begin
        w_reg_write = 1'b1;
        w_alu_op    = 2'b10;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      C_OP_IALU: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_op    = 2'b11;
        w_uses_rs1  = 1'b1;
      end
      C_OP_LOAD: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_mem_read   = 1'b1;
        w_alu_src    = 1'b1;
        w_uses_rs1   = 1'b1;
      end
      C_OP_STORE: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      C_OP_BRANCH: begin
        w_branch   = 1'b1;
        w_alu_op   = 2'b01;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      default: begin
        w_reg_write = 1'b0;
      end
    endcase
  end

  // A load in EX whose destination feeds an operand the ID instruction
  // actually reads must hold the front end for one cycle; x0 never hazards
  // and a redirect overrides the stall so the branch target can load.
  assign w_load_use = MemRead_EX && (RD_EX != 5'd0) &&
                      ((w_uses_rs1 && (RD_EX == RS1_ID)) ||
                       (w_uses_rs2 && (RD_EX == RS2_ID)));
  assign w_stall     = w_load_use && !flush;
  assign PC_write    = !w_stall;
  assign IF_ID_write = !w_stall;

  // ID/EX pipeline register: bubble on flush or stall, otherwise capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush || w_stall) begin
      PC_EX        <= '0;
      REG_DATA1_EX <= '0;
      REG_DATA2_EX <= '0;
      IMM_EX       <= '0;
      FUNCT3_EX    <= '0;
      FUNCT7_EX    <= '0;
      RD_EX        <= '0;
      RS1_EX       <= '0;
      RS2_EX       <= '0;
      RegWrite_EX  <= 1'b0;
      MemtoReg_EX  <= 1'b0;
      MemRead_EX   <= 1'b0;
      MemWrite_EX  <= 1'b0;
      ALUSrc_EX    <= 1'b0;
      Branch_EX    <= 1'b0;
      ALUOp_EX     <= 2'b00;
    end else begin
      PC_EX        <= PC_ID;
      REG_DATA1_EX <= REG_DATA1_ID;
      REG_DATA2_EX <= REG_DATA2_ID;
      IMM_EX       <= IMM_ID;
      FUNCT3_EX    <= FUNCT3_ID;
      FUNCT7_EX    <= FUNCT7_ID;
      RD_EX        <= RD_ID;
      RS1_EX       <= RS1_ID;
      RS2_EX       <= RS2_ID;
      RegWrite_EX  <= w_reg_write;
      MemtoReg_EX  <= w_mem_to_reg;
      MemRead_EX   <= w_mem_read;
      MemWrite_EX  <= w_mem_write;
      ALUSrc_EX    <= w_alu_src;
      Branch_EX    <= w_branch;
      ALUOp_EX     <= w_alu_op;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_id_ex.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_id_ex
// Description : Self-checking bench for riscv_id_ex against a table-driven
//               behavioural model of the decode/hazard/pipeline rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_id_ex;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic [XLEN-1:0] PC_ID = '0, REG_DATA1_ID = '0, REG_DATA2_ID = '0, IMM_ID = '0;
  logic [2:0] FUNCT3_ID = '0;
  logic [6:0] FUNCT7_ID = '0, OPCODE_ID = '0;
  logic [4:0] RD_ID = '0, RS1_ID = '0, RS2_ID = '0;
  logic PC_write, IF_ID_write;
  logic [XLEN-1:0] PC_EX, REG_DATA1_EX, REG_DATA2_EX, IMM_EX;
  logic [2:0] FUNCT3_EX;
  logic [6:0] FUNCT7_EX;
  logic [4:0] RD_EX, RS1_EX, RS2_EX;
  logic RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX, Branch_EX;
  logic [1:0] ALUOp_EX;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  riscv_id_ex #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .PC_ID(PC_ID), .REG_DATA1_ID(REG_DATA1_ID), .REG_DATA2_ID(REG_DATA2_ID),
    .IMM_ID(IMM_ID), .FUNCT3_ID(FUNCT3_ID), .FUNCT7_ID(FUNCT7_ID),
    .OPCODE_ID(OPCODE_ID), .RD_ID(RD_ID), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .PC_EX(PC_EX), .REG_DATA1_EX(REG_DATA1_EX), .REG_DATA2_EX(REG_DATA2_EX),
    .IMM_EX(IMM_EX), .FUNCT3_EX(FUNCT3_EX), .FUNCT7_EX(FUNCT7_EX),
    .RD_EX(RD_EX), .RS1_EX(RS1_EX), .RS2_EX(RS2_EX),
    .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX), .MemRead_EX(MemRead_EX),
    .MemWrite_EX(MemWrite_EX), .ALUSrc_EX(ALUSrc_EX), .Branch_EX(Branch_EX),
    .ALUOp_EX(ALUOp_EX)
  );

  always #5 clk = ~clk;

  // Model state: expected EX contents. Control vector order:
  // {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, Branch, ALUOp[1:0]}
  logic [XLEN-1:0] m_pc = '0, m_d1 = '0, m_d2 = '0, m_imm = '0;
  logic [2:0] m_f3 = '0;
  logic [6:0] m_f7 = '0;
  logic [4:0] m_rd = '0, m_rs1 = '0, m_rs2 = '0;
  logic [7:0] m_ctl = '0;

  function automatic logic [7:0] ctl_of(input logic [6:0] op);
    case (op)
      OP_R:    return 8'b1000_0010;
      OP_I:    return 8'b1000_1011;
      OP_L:    return 8'b1110_1000;
      OP_S:    return 8'b0001_1000;
      OP_B:    return 8'b0000_0101;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic bit model_stall();
    bit reads1, reads2, hz;
    reads1 = (OPCODE_ID inside {OP_R, OP_I, OP_L, OP_S, OP_B});
    reads2 = (OPCODE_ID inside {OP_R, OP_S, OP_B});
    hz = m_ctl[5] && (m_rd != 0) &&
         ((reads1 && m_rd == RS1_ID) || (reads2 && m_rd == RS2_ID));
    return hz && !flush;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_ctl();
    return {RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX,
            ALUSrc_EX, Branch_EX, ALUOp_EX};
  endfunction

  // Reference model update: bubble on reset/flush/stall, else capture.
  always @(posedge clk or posedge reset) begin
    bit b;
    b = reset || flush || model_stall();
    if (b) begin
      m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0; m_f3 = '0; m_f7 = '0;
      m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_ctl = '0;
    end else begin
      m_pc = PC_ID; m_d1 = REG_DATA1_ID; m_d2 = REG_DATA2_ID; m_imm = IMM_ID;
      m_f3 = FUNCT3_ID; m_f7 = FUNCT7_ID; m_rd = RD_ID; m_rs1 = RS1_ID;
      m_rs2 = RS2_ID; m_ctl = ctl_of(OPCODE_ID);
    end
  end

  // Compare process: every falling edge, all outputs vs. the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("pc_ex", PC_EX, m_pc);
      chk("rd1_ex", REG_DATA1_EX, m_d1);
      chk("rd2_ex", REG_DATA2_EX, m_d2);
      chk("imm_ex", IMM_EX, m_imm);
      chk("f3_ex", {29'd0, FUNCT3_EX}, {29'd0, m_f3});
      chk("f7_ex", {25'd0, FUNCT7_EX}, {25'd0, m_f7});
      chk("rd_ex", {27'd0, RD_EX}, {27'd0, m_rd});
      chk("rs1_ex", {27'd0, RS1_EX}, {27'd0, m_rs1});
      chk("rs2_ex", {27'd0, RS2_EX}, {27'd0, m_rs2});
      chk("ctl_ex", {24'd0, dut_ctl()}, {24'd0, m_ctl});
      chk("pc_write", {31'd0, PC_write}, {31'd0, !model_stall()});
      chk("if_id_write", {31'd0, IF_ID_write}, {31'd0, !model_stall()});
    end
  end

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] d1, input logic [31:0] pc,
                       input logic fl);
    OPCODE_ID = op; RD_ID = rd; RS1_ID = rs1; RS2_ID = rs2;
    REG_DATA1_ID = d1; PC_ID = pc; flush = fl;
    REG_DATA2_ID = d1 ^ 32'h5a5a_0000; IMM_ID = pc + 32'd4;
    FUNCT3_ID = pc[2:0]; FUNCT7_ID = d1[6:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit s;
    // Reset held from time 0; release away from an edge.
    step();
    step();
    reset = 1'b0;
    run_cmp = 1'b1;

    // Build non-zero EX state, then reset asynchronously mid-cycle.
    drive(OP_L, 5'd9, 5'd1, 5'd2, 32'h1234, 32'h40, 1'b0);
    step();
    drive(OP_R, 5'd1, 5'd2, 5'd3, 32'h0, 32'h44, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("reset_pc_ex", PC_EX, 32'h0);
    chk("reset_ctl_ex", {24'd0, dut_ctl()}, 32'h0);
    chk("reset_rd_ex", {27'd0, RD_EX}, 32'h0);
    chk("reset_pc_write", {31'd0, PC_write}, 32'h1);
    chk("reset_if_id_write", {31'd0, IF_ID_write}, 32'h1);
    step();
    reset = 1'b0;

    // R-type passthrough.
    drive(OP_R, 5'd5, 5'd1, 5'd2, 32'h11, 32'h8, 1'b0);
    step();
    chk("rtype_rd", {27'd0, RD_EX}, 32'd5);
    chk("rtype_d1", REG_DATA1_EX, 32'h11);
    chk("rtype_pc", PC_EX, 32'h8);
    chk("rtype_ctl", {24'd0, dut_ctl()}, 32'h82);

    // Load-use on rs1: one stall cycle, one bubble, then capture.
    drive(OP_L, 5'd3, 5'd1, 5'd0, 32'h0, 32'hC, 1'b0);
    step();
    drive(OP_I, 5'd6, 5'd3, 5'd0, 32'h22, 32'h10, 1'b0);
    #1;
    chk("lu1_pc_write", {31'd0, PC_write}, 32'h0);
    chk("lu1_if_id_write", {31'd0, IF_ID_write}, 32'h0);
    step();
    chk("lu1_bubble_ctl", {24'd0, dut_ctl()}, 32'h0);
    chk("lu1_bubble_pc", PC_EX, 32'h0);
    chk("lu1_resume_pc_write", {31'd0, PC_write}, 32'h1);
    step();
    chk("lu1_addi_aluop", {30'd0, ALUOp_EX}, 32'h3);
    chk("lu1_addi_rd", {27'd0, RD_EX}, 32'd6);

    // rs2 field of an I-type is not a real operand.
    drive(OP_L, 5'd4, 5'd1, 5'd0, 32'h0, 32'h14, 1'b0);
    step();
    drive(OP_I, 5'd7, 5'd1, 5'd4, 32'h0, 32'h18, 1'b0);
    #1 chk("lu2_addi_no_stall", {31'd0, PC_write}, 32'h1);
    step();
    drive(OP_L, 5'd4, 5'd1, 5'd0, 32'h0, 32'h1C, 1'b0);
    step();
    drive(OP_S, 5'd0, 5'd1, 5'd4, 32'h0, 32'h20, 1'b0);
    #1 chk("lu2_store_stall", {31'd0, PC_write}, 32'h0);
    step();
    step();
    chk("lu2_store_ctl", {24'd0, dut_ctl()}, 32'h18);

    // Load to x0 never stalls.
    drive(OP_L, 5'd0, 5'd1, 5'd0, 32'h0, 32'h24, 1'b0);
    step();
    drive(OP_R, 5'd8, 5'd0, 5'd0, 32'h33, 32'h28, 1'b0);
    #1 chk("x0_no_stall", {31'd0, PC_write}, 32'h1);
    step();
    chk("x0_capture_rd", {27'd0, RD_EX}, 32'd8);

    // Flush beats load-use.
    drive(OP_L, 5'd7, 5'd1, 5'd0, 32'h0, 32'h2C, 1'b0);
    step();
    drive(OP_I, 5'd9, 5'd7, 5'd0, 32'h0, 32'h30, 1'b1);
    #1;
    chk("flush_pc_write", {31'd0, PC_write}, 32'h1);
    chk("flush_if_id_write", {31'd0, IF_ID_write}, 32'h1);
    step();
    chk("flush_bubble_ctl", {24'd0, dut_ctl()}, 32'h0);
    chk("flush_bubble_pc", PC_EX, 32'h0);
    flush = 1'b0;

    // Randomized traffic; a stalled front end re-presents its instruction.
    for (int i = 0; i < 3000; i++) begin
      s = model_stall();
      step();
      reset = 1'b0;
      if (!s) begin
        case ($urandom_range(0, 6))
          0: OPCODE_ID = OP_R;
          1: OPCODE_ID = OP_I;
          2, 3: OPCODE_ID = OP_L;
          4: OPCODE_ID = OP_S;
          5: OPCODE_ID = OP_B;
          default: OPCODE_ID = 7'($urandom);
        endcase
        RD_ID = 5'($urandom_range(0, 5));
        RS1_ID = 5'($urandom_range(0, 5));
        RS2_ID = 5'($urandom_range(0, 5));
        PC_ID = $urandom; REG_DATA1_ID = $urandom; REG_DATA2_ID = $urandom;
        IMM_ID = $urandom; FUNCT3_ID = 3'($urandom); FUNCT7_ID = 7'($urandom);
      end
      flush = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b1;
      end
    end
    step();
    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/riscv_id_ex.md
# riscv_id_ex

Decode-to-execute boundary of the 5-stage RISC-V core: main control decode, load-use hazard detection and the ID/EX pipeline register. Consumes the decoded fields produced by the IF/ID front end (PC, operands, immediate, funct/opcode, register indices). Drives the `PC_write` / `IF_ID_write` stall controls back into that front end. Presents registered operands and control bits to the EX stage.

## Interface
Parameters:
- `XLEN`, 32, datapath width.

Ports (outputs suffixed `_EX` are registered):
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `flush`  in  1  branch-taken redirect from EX/MEM (PCSrc); squashes the instruction in ID.
- `PC_ID`  in  XLEN  PC of the instruction in ID.
- `REG_DATA1_ID`, `REG_DATA2_ID`  in  XLEN  register file read data.
- `IMM_ID`  in  XLEN  sign-extended immediate.
- `FUNCT3_ID`  in  3  instruction funct3.
- `FUNCT7_ID`  in  7  instruction funct7.
- `OPCODE_ID`  in  7  instruction opcode.
- `RD_ID`, `RS1_ID`, `RS2_ID`  in  5 each  register indices.
- `PC_write`  out  1  combinational; 0 freezes the PC.
- `IF_ID_write`  out  1  combinational; 0 freezes the IF/ID register.
- `PC_EX`, `REG_DATA1_EX`, `REG_DATA2_EX`, `IMM_EX`  out  XLEN  registered datapath fields.
- `FUNCT3_EX` (3), `FUNCT7_EX` (7), `RD_EX`, `RS1_EX`, `RS2_EX` (5 each)  out  registered fields.
- `RegWrite_EX`, `MemtoReg_EX`, `MemRead_EX`, `MemWrite_EX`, `ALUSrc_EX`, `Branch_EX`  out  1 each  registered controls.
- `ALUOp_EX`  out  2  registered ALU operation class.

## Operation
Control decode, a combinational function of `OPCODE_ID`:
- R-type, 0110011: RegWrite=1, ALUSrc=0, ALUOp=10.
- I-ALU, 0010011: RegWrite=1, ALUSrc=1, ALUOp=11.
- LOAD, 0000011: RegWrite=1, MemtoReg=1, MemRead=1, ALUSrc=1, ALUOp=00.
- STORE, 0100011: MemWrite=1, ALUSrc=1, ALUOp=00.
- BRANCH, 1100011: Branch=1, ALUOp=01.
- Any other opcode, including all-zero: every control bit 0. This is a NOP.
- Control bits not listed for an opcode are 0.

Load-use hazard detection, combinational:
- `uses_rs2` = opcode is R-type, STORE or BRANCH.
- `uses_rs1` = opcode is any of the five decoded classes.
- `load_use` = `MemRead_EX` & (`RD_EX` != 0) & ((`uses_rs1` & `RD_EX`==`RS1_ID`) | (`uses_rs2` & `RD_EX`==`RS2_ID`)).
- `stall` = `load_use` & ~`flush`.
- `PC_write` = `IF_ID_write` = ~`stall`.

ID/EX register update, every rising edge:
- If `flush` or `stall`, load a bubble: every `_EX` output becomes 0.
- Otherwise, capture all `_ID` fields and the decoded controls.
- A bubble holds `MemRead_EX`=0, so a stall lasts exactly one cycle.
- When stall clears, the held instruction is re-presented on the `_ID` inputs by the frozen front end. It is then captured normally.

## Timing
- Latency: `_ID` inputs to `_EX` outputs is 1 cycle.
- `PC_write` and `IF_ID_write` respond combinationally, in the same cycle, to `_ID` inputs and `_EX` state.
- Reset, asynchronous: all `_EX` outputs go to 0 immediately.
  - `PC_write`=`IF_ID_write`=1 while reset is high, because `MemRead_EX`=0.
- Reset deasserted: the first capture happens on the next rising edge.
- Reset asserted mid-stall: the stall ends immediately and the bubble state is held.
- `flush` and `load_use` in the same cycle: flush wins.
  - Bubble inserted.
  - `PC_write`=1, so the branch target can load.
  - No stall.
- A load with `RD_EX`=x0 never stalls.
- Back-to-back loads to dependent registers: each dependent consumer stalls exactly one cycle.
- No internal wrap-around or counters; the PC value passes through unmodified.

## Test plan
- Reset: assert `reset` mid-cycle with non-zero `_EX` state -> all `_EX` outputs read 0 before the next edge; `PC_write`=`IF_ID_write`=1.
- R-type passthrough: `OPCODE_ID`=0110011, `RD_ID`=5, `REG_DATA1_ID`=0x11, `PC_ID`=0x8 -> next cycle `RD_EX`=5, `REG_DATA1_EX`=0x11, `PC_EX`=0x8, `RegWrite_EX`=1, `ALUOp_EX`=10, `ALUSrc_EX`=0.
- Load-use on rs1: LOAD with rd=3 captured; ID then holds `addi` with rs1=3 -> `PC_write`=`IF_ID_write`=0 for one cycle; next `_EX` is all zeros; the following cycle captures the `addi` with `ALUOp_EX`=11.
- Load-use on rs2 only applies when used:
  - LOAD rd=4 followed by `addi` with `RS2_ID` field=4 -> no stall.
  - LOAD rd=4 followed by STORE with rs2=4 -> one-cycle stall.
- x0 load: LOAD rd=0 followed by R-type with rs1=0 -> no stall; normal capture.
- Flush priority: load-use condition present and `flush`=1 in the same cycle -> `PC_write`=1, `IF_ID_write`=1, and the next `_EX` is all zeros.
